// File: rtl/cpu_rf_wr_arbiter_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
// Build option RF_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package cpu_rf_wr_arbiter_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_WR_N_REQ = 3;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/cpu_rf_wr_arbiter_if.sv
// Writeback requester bundle: N_REQ valid/ready lanes with addr/data.
// Requesters use master, the arbiter uses slave.
interface cpu_rf_wr_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/cpu_rr_arbiter.sv
// Generic N-input round-robin arbiter with registered pointer.
// RF_ARB_FIXED_PRIO_EN turns it into lowest-index-wins fixed priority.
module cpu_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

`ifdef RF_ARB_FIXED_PRIO_EN
    assign gnt = req & (~req + N'(1));
`else
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  hi;
    logic [N-1:0]  hi_gnt;
    logic [N-1:0]  lo_gnt;

    // Requests at or above the pointer win; otherwise wrap to the lowest.
    assign hi     = req & ~((N'(1) << ptr) - N'(1));
    assign hi_gnt = hi & (~hi + N'(1));
    assign lo_gnt = req & (~req + N'(1));
    assign gnt    = (|hi) ? hi_gnt : lo_gnt;

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`endif

endmodule

// File: rtl/cpu_rf_wr_arbiter.sv
// Register-file write-port arbiter with busy scoreboard for RAW checks.
// Build option RF_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module cpu_rf_wr_arbiter
    import cpu_rf_wr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int N_REQ      = RF_WR_N_REQ
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_rf_wr_arbiter_if.slave    wb,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] chk_a1,
    input  logic [ADDR_WIDTH-1:0] chk_a2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  wen3,
    output logic [ADDR_WIDTH-1:0] a3,
    output logic [DATA_WIDTH-1:0] wd3
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [N_REQ-1:0]      gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;

    cpu_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb.req_valid),
        .gnt   (gnt)
    );

    assign wb.req_ready = gnt;
    assign xfer         = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // x0 writes are consumed here so the bank never sees them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen3 <= 1'b0;
            a3   <= '0;
            wd3  <= '0;
        end else if (xfer) begin
            wen3 <= (sel_addr != '0);
            a3   <= sel_addr;
            wd3  <= sel_data;
        end else begin
            wen3 <= 1'b0;
        end
    end

    // Clear first so a same-edge reservation of the written reg wins.
    always_comb begin
        busy_nxt = busy;
        if (wen3) begin
            busy_nxt[a3] = 1'b0;
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign chk_busy1 = (chk_a1 != '0) & busy[chk_a1];
    assign chk_busy2 = (chk_a2 != '0) & busy[chk_a2];

`ifdef DESIGNER_ASSERTIONS
    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt));

    a_no_rsv_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        (rsv_en && rsv_addr != '0) |-> !busy[rsv_addr]);

    a_wen_nz: assert property (
        @(posedge clk) disable iff (!rst_n) wen3 |-> (a3 != '0));

    for (genvar g = 0; g < N_REQ; g++) begin : g_stable
        a_hold: assert property (
            @(posedge clk) disable iff (!rst_n)
            (wb.req_valid[g] && !gnt[g]) |=>
            (wb.req_valid[g]
             && $stable(wb.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH])
             && $stable(wb.req_data[g*DATA_WIDTH +: DATA_WIDTH])));
    end
`endif

endmodule
